// File: rtl/cache_line_sequencer_pkg.sv
// Shared types and constants for the cache line miss sequencer.
// Contents: FSM state encoding, cache_data geometry constants.
// No logic; imported by cache_line_sequencer.
package cache_line_sequencer_pkg;

    localparam int SEG_W  = 9;
    localparam int WAY_W  = 2;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        PROBE,
        EVAL,
        WB,
        FILL,
        WRITE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/cache_line_sequencer.sv
// Line-miss sequencer: probe victim, write back if dirty, fetch new line, full-write it into cache_data.
// Latency: miss_req to miss_done = 5 cycles + fill wait (+2 + write-back wait when the victim is dirty).
// Backpressure: mem_req held until mem_ack; a watchdog aborts with miss_err after TIMEOUT unacked cycles.
//
// Ports:
//   main_clk / main_rst_n        clock, async active-low reset
//   miss_*                       miss request from tag logic (level, held until miss_done/miss_err)
//   victim_tag                   tag of the evicted line, latched with the miss
//   busy, cd_own, cd_target_*    cache_data ownership and address
//   cd_do_full_write, cd_raw_in  full-line write into cache_data
//   cd_raw_out, cd_out_dirty     cache_data read data / dirty flag, valid one cycle after address
//   mem_*                        128-bit line bus to the memory controller
//   wb_count                     saturating count of completed write-backs
module cache_line_sequencer
    import cache_line_sequencer_pkg::*;
#(
    parameter int TAG_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                    main_clk,
    input  logic                    main_rst_n,
    input  logic                    miss_req,
    input  logic [SEG_W-1:0]        miss_segment,
    input  logic [WAY_W-1:0]        miss_way,
    input  logic [TAG_W-1:0]        miss_tag,
    input  logic [TAG_W-1:0]        victim_tag,
    output logic                    miss_done,
    output logic                    miss_err,
    output logic                    busy,
    output logic                    cd_own,
    output logic [SEG_W-1:0]        cd_target_segment,
    output logic [WAY_W-1:0]        cd_target_way,
    output logic                    cd_do_full_write,
    output logic [LINE_W-1:0]       cd_raw_in,
    input  logic [LINE_W-1:0]       cd_raw_out,
    input  logic                    cd_out_dirty,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [TAG_W+SEG_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]       mem_wdata,
    input  logic [LINE_W-1:0]       mem_rdata,
    input  logic                    mem_ack,
    output logic [CNT_W-1:0]        wb_count
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    seq_state_t         state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [WAY_W-1:0]   way_q, way_d;
    logic [TAG_W-1:0]   mtag_q, mtag_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [CNT_W-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0]   wb_count_q, wb_count_d;
    // Set for the first FILL cycle after a write-back so mem_req drops for one cycle.
    logic               gap_q, gap_d;
    logic               wd_fire;

    assign wd_fire           = (TIMEOUT != 0) && (wd_q == TMO);
    assign busy              = (state_q != IDLE);
    assign cd_target_segment = seg_q;
    assign cd_target_way     = way_q;
    assign cd_raw_in         = line_q;
    assign mem_wdata         = line_q;
    assign wb_count          = wb_count_q;

    always_comb begin
        state_d          = state_q;
        seg_d            = seg_q;
        way_d            = way_q;
        mtag_d           = mtag_q;
        vtag_d           = vtag_q;
        line_d           = line_q;
        wd_d             = wd_q;
        wb_count_d       = wb_count_q;
        gap_d            = 1'b0;
        cd_own           = 1'b1;
        cd_do_full_write = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        miss_done        = 1'b0;
        miss_err         = 1'b0;

        case (state_q)
            IDLE: begin
                cd_own = 1'b0;
                if (miss_req) begin
                    seg_d   = miss_segment;
                    way_d   = miss_way;
                    mtag_d  = miss_tag;
                    vtag_d  = victim_tag;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                state_d = EVAL;
            end
            EVAL: begin
                wd_d = '0;
                if (cd_out_dirty) begin
                    line_d  = cd_raw_out;
                    state_d = WB;
                end else begin
                    state_d = FILL;
                end
            end
            WB: begin
                mem_we   = 1'b1;
                mem_addr = {vtag_q, seg_q};
                if (wd_fire) begin
                    miss_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        wb_count_d = (wb_count_q == '1) ? wb_count_q : wb_count_q + 1'b1;
                        wd_d       = '0;
                        gap_d      = 1'b1;
                        state_d    = FILL;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            FILL: begin
                mem_addr = {mtag_q, seg_q};
                if (gap_q) begin
                    // Idle bus cycle between write-back and fill; mem_ack is ignored here.
                end else if (wd_fire) begin
                    miss_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        line_d  = mem_rdata;
                        state_d = WRITE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                cd_do_full_write = 1'b1;
                state_d          = DONE;
            end
            DONE: begin
                cd_own    = 1'b0;
                miss_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                cd_own  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            state_q    <= IDLE;
            seg_q      <= '0;
            way_q      <= '0;
            mtag_q     <= '0;
            vtag_q     <= '0;
            line_q     <= '0;
            wd_q       <= '0;
            wb_count_q <= '0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            way_q      <= way_d;
            mtag_q     <= mtag_d;
            vtag_q     <= vtag_d;
            line_q     <= line_d;
            wd_q       <= wd_d;
            wb_count_q <= wb_count_d;
            gap_q      <= gap_d;
        end
    end

endmodule

// File: tb/tb_cache_line_sequencer.sv
module tb_cache_line_sequencer;

    localparam int TAG_W = 16;
    localparam int TMO   = 8;

    logic               main_clk = 1'b0;
    logic               main_rst_n = 1'b0;
    logic               miss_req = 1'b0;
    logic [8:0]         miss_segment = '0;
    logic [1:0]         miss_way = '0;
    logic [TAG_W-1:0]   miss_tag = '0;
    logic [TAG_W-1:0]   victim_tag = '0;
    logic               miss_done, miss_err, busy, cd_own;
    logic [8:0]         cd_target_segment;
    logic [1:0]         cd_target_way;
    logic               cd_do_full_write;
    logic [127:0]       cd_raw_in;
    logic [127:0]       cd_raw_out = '0;
    logic               cd_out_dirty = 1'b0;
    logic               mem_req, mem_we;
    logic [TAG_W+8:0]   mem_addr;
    logic [127:0]       mem_wdata;
    logic [127:0]       mem_rdata = '0;
    logic               mem_ack = 1'b0;
    logic [15:0]        wb_count;

    cache_line_sequencer #(.TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
        .main_clk(main_clk), .main_rst_n(main_rst_n),
        .miss_req(miss_req), .miss_segment(miss_segment), .miss_way(miss_way),
        .miss_tag(miss_tag), .victim_tag(victim_tag),
        .miss_done(miss_done), .miss_err(miss_err), .busy(busy), .cd_own(cd_own),
        .cd_target_segment(cd_target_segment), .cd_target_way(cd_target_way),
        .cd_do_full_write(cd_do_full_write), .cd_raw_in(cd_raw_in),
        .cd_raw_out(cd_raw_out), .cd_out_dirty(cd_out_dirty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_count(wb_count)
    );

    always #5 main_clk = ~main_clk;

    int cyc = 0;
    always @(posedge main_clk) cyc <= cyc + 1;

    int vecs = 0;
    int misc = 0;

    task automatic chk(input string nm, input logic [127:0] act_v, input logic [127:0] exp_v);
        vecs++;
        if (act_v !== exp_v) begin
            misc++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    // Memory responder: acks after a programmed number of wait cycles, or every cycle when tied.
    bit ack_tied = 1'b0;
    int wb_wait = 0;
    int fill_wait = 0;
    int mcnt = 0;
    always @(negedge main_clk) begin
        if (ack_tied) begin
            mem_ack = 1'b1;
        end else if (mem_req) begin
            if (mcnt == (mem_we ? wb_wait : fill_wait)) begin
                mem_ack = 1'b1;
                mcnt = 0;
            end else begin
                mem_ack = 1'b0;
                mcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            mcnt = 0;
        end
    end

    // Transaction model: one outstanding miss described by its start cycle and memory waits.
    bit           act = 1'b0;
    int           t_start = 0;
    bit           t_dirty = 1'b0;
    bit           t_tmo = 1'b0;
    int           t_w1 = 0;
    int           t_w2 = 0;
    logic [8:0]   t_seg = '0;
    logic [1:0]   t_way = '0;
    logic [15:0]  t_mtag = '0;
    logic [15:0]  t_vtag = '0;
    logic [127:0] t_line = '0;
    logic [127:0] t_fill = '0;
    logic [15:0]  wbc_base = '0;

    always begin : cmp
        int rel, fs, fe, endr;
        bit e_busy, e_own, e_wb, e_fill, e_req, e_wr, e_done, e_err;
        logic [15:0] e_cnt;
        @(posedge main_clk);
        #1;
        if (main_rst_n) begin
            rel  = act ? (cyc - t_start) : -1;
            fs   = t_dirty ? (5 + t_w1) : 3;
            fe   = t_tmo ? (fs + TMO - 1) : (fs + t_w2);
            endr = t_tmo ? (fs + TMO) : (fe + 2);
            if (rel > endr) rel = -1;
            e_busy = (rel >= 1) && (rel <= endr);
            e_own  = (rel >= 1) && (rel <= (t_tmo ? endr : endr - 1));
            e_wb   = t_dirty && (rel >= 3) && (rel <= 3 + t_w1);
            e_fill = (rel >= fs) && (rel <= fe);
            e_req  = e_wb || e_fill;
            e_wr   = !t_tmo && (rel == fe + 1);
            e_done = !t_tmo && (rel == endr);
            e_err  = t_tmo && (rel == endr);
            e_cnt  = wbc_base;
            if (t_dirty && (rel >= 4 + t_w1) && (wbc_base != 16'hFFFF)) e_cnt = wbc_base + 16'd1;

            chk("busy", busy, e_busy);
            chk("cd_own", cd_own, e_own);
            chk("mem_req", mem_req, e_req);
            chk("miss_done", miss_done, e_done);
            chk("miss_err", miss_err, e_err);
            chk("cd_do_full_write", cd_do_full_write, e_wr);
            chk("wb_count", wb_count, e_cnt);
            if (e_own) begin
                chk("cd_target_segment", cd_target_segment, t_seg);
                chk("cd_target_way", cd_target_way, t_way);
            end
            if (e_req) begin
                chk("mem_we", mem_we, e_wb);
                chk("mem_addr", mem_addr, e_wb ? {t_vtag, t_seg} : {t_mtag, t_seg});
                if (e_wb) chk("mem_wdata", mem_wdata, t_line);
            end
            if (e_wr) chk("cd_raw_in", cd_raw_in, t_fill);
        end
    end

    // Called at a negedge; off=0 when the DUT is idle now, off=1 when it is in DONE now.
    task automatic start_miss(input logic [8:0] seg, input logic [1:0] way,
                              input logic [15:0] mt, input logic [15:0] vt,
                              input bit dirty, input logic [127:0] line, input logic [127:0] fill,
                              input int w1, input int w2, input bit tmo, input int off);
        miss_segment = seg;  miss_way = way;  miss_tag = mt;  victim_tag = vt;
        cd_out_dirty = dirty; cd_raw_out = line; mem_rdata = fill;
        wb_wait = w1; fill_wait = w2;
        t_seg = seg; t_way = way; t_mtag = mt; t_vtag = vt; t_dirty = dirty;
        t_line = line; t_fill = fill; t_w1 = w1; t_w2 = w2; t_tmo = tmo;
        t_start = cyc + off;
        act = 1'b1;
        miss_req = 1'b1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 50) begin
            @(negedge main_clk);
            n++;
        end
        if (!mem_req) begin
            vecs++; misc++;
            $display("FAIL wait_req: got no mem_req expected mem_req within 50 cycles");
        end
    endtask

    task automatic wait_end(output int lat);
        int n = 0;
        do begin
            @(negedge main_clk);
            n++;
        end while (!(miss_done || miss_err) && n < 2000);
        if (!(miss_done || miss_err)) begin
            vecs++; misc++;
            $display("FAIL wait_end: got no miss_done/miss_err expected one within 2000 cycles");
        end
        lat = cyc - t_start;
        miss_req = 1'b0;
        if (t_dirty && !t_tmo && wbc_base != 16'hFFFF) wbc_base = wbc_base + 16'd1;
        act = 1'b0;
    endtask

    localparam logic [127:0] DIRTY_LINE = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] FILL_A     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] FILL_B     = 128'hA5A5_5A5A_0F0F_F0F0_CAFE_F00D_1234_5678;

    initial begin
        int lat;
        // Reset state
        repeat (2) @(negedge main_clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cd_own", cd_own, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_miss_done", miss_done, 1'b0);
        chk("rst_miss_err", miss_err, 1'b0);
        chk("rst_full_write", cd_do_full_write, 1'b0);
        chk("rst_wb_count", wb_count, 16'h0);
        chk("rst_mem_addr", mem_addr, 25'h0);
        chk("rst_cd_raw_in", cd_raw_in, 128'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        main_rst_n = 1'b1;
        repeat (2) @(negedge main_clk);

        // Clean miss, fill acked after 3 wait cycles
        start_miss(9'h1A5, 2'd2, 16'h1234, 16'hABCD, 1'b0, 128'h0, FILL_A, 0, 3, 1'b0, 0);
        wait_req();
        chk("clean_first_req_we", mem_we, 1'b0);
        chk("clean_fill_addr", mem_addr, 25'h02469A5);
        wait_end(lat);
        chk("clean_latency", lat, 8);
        chk("clean_wb_count", wb_count, 16'd0);
        repeat (2) @(negedge main_clk);

        // Dirty miss: write-back waits 2, fill waits 1
        start_miss(9'h03C, 2'd1, 16'h5555, 16'hBEEF, 1'b1, DIRTY_LINE, FILL_B, 2, 1, 1'b0, 0);
        wait_req();
        chk("dirty_wb_we", mem_we, 1'b1);
        chk("dirty_wb_addr", mem_addr, 25'h17DDE3C);
        chk("dirty_wb_wdata", mem_wdata, DIRTY_LINE);
        wait_end(lat);
        chk("dirty_latency", lat, 10);
        chk("dirty_wb_count", wb_count, 16'd1);
        repeat (2) @(negedge main_clk);

        // Zero-wait memory with mem_ack tied high, then a back-to-back clean miss
        ack_tied = 1'b1;
        repeat (2) @(negedge main_clk);
        start_miss(9'h0FF, 2'd3, 16'h0F0F, 16'h7001, 1'b1, FILL_A, DIRTY_LINE, 0, 0, 1'b0, 0);
        wait_end(lat);
        chk("zw_dirty_latency", lat, 7);
        start_miss(9'h100, 2'd0, 16'h2222, 16'h3333, 1'b0, 128'h0, FILL_B, 0, 0, 1'b0, 1);
        wait_end(lat);
        chk("b2b_clean_latency", lat, 5);
        chk("zw_wb_count", wb_count, 16'd2);
        ack_tied = 1'b0;
        repeat (2) @(negedge main_clk);

        // Watchdog: fill never acked
        start_miss(9'h055, 2'd1, 16'h4444, 16'h6666, 1'b0, 128'h0, FILL_A, 0, 1000, 1'b1, 0);
        wait_end(lat);
        chk("tmo_err_pulse", miss_err, 1'b1);
        chk("tmo_latency", lat, 11);
        @(negedge main_clk);
        chk("tmo_busy_after", busy, 1'b0);
        chk("tmo_mem_req_after", mem_req, 1'b0);
        fill_wait = 0;
        repeat (2) @(negedge main_clk);

        // Reset while a write-back is pending
        start_miss(9'h1FF, 2'd2, 16'h8888, 16'h9999, 1'b1, DIRTY_LINE, FILL_B, 1000, 0, 1'b0, 0);
        wait_req();
        @(negedge main_clk);
        chk("prerst_mem_req", mem_req, 1'b1);
        main_rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_wb_count", wb_count, 16'd0);
        act = 1'b0;
        wbc_base = 16'd0;
        miss_req = 1'b0;
        wb_wait = 0;
        @(negedge main_clk);
        main_rst_n = 1'b1;
        repeat (2) @(negedge main_clk);
        start_miss(9'h011, 2'd0, 16'hFACE, 16'h0001, 1'b0, 128'h0, FILL_A, 0, 0, 1'b0, 0);
        wait_end(lat);
        chk("postrst_latency", lat, 5);
        repeat (2) @(negedge main_clk);

        // Saturation: preload the counter one below full
        force dut.wb_count_q = 16'hFFFE;
        wbc_base = 16'hFFFE;
        @(negedge main_clk);
        release dut.wb_count_q;
        repeat (2) @(negedge main_clk);
        start_miss(9'h0AA, 2'd1, 16'h1111, 16'h2222, 1'b1, FILL_B, FILL_A, 0, 0, 1'b0, 0);
        wait_end(lat);
        chk("sat_first", wb_count, 16'hFFFF);
        repeat (2) @(negedge main_clk);
        start_miss(9'h0AB, 2'd2, 16'h3333, 16'h4444, 1'b1, FILL_A, FILL_B, 1, 0, 1'b0, 0);
        wait_end(lat);
        chk("sat_hold", wb_count, 16'hFFFF);
        repeat (3) @(negedge main_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected finish before 200000 time units");
        $fatal(1, "simulation time limit");
    end

endmodule
